// File: rtl/kws_simd_mac_pkg.sv
// Shared opcodes, FSM states and arithmetic widths for the KWS SIMD MAC pipeline.
package kws_simd_mac_pkg;

  localparam int ELEM_W = 8;
  localparam int OFF_W  = 9;
  localparam int PROD_W = 17;

  typedef enum logic [2:0] {
    OP_MAC     = 3'd0,
    OP_MAC1    = 3'd1,
    OP_SETOFF  = 3'd2,
    OP_READ    = 3'd3,
    OP_CLEAR   = 3'd4,
    OP_READCLR = 3'd5,
    OP_NOP6    = 3'd6,
    OP_NOP7    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Every doubling of the lane count adds one carry bit to the reduction.
  function automatic int lane_sum_w(input int lanes);
    return PROD_W + $clog2(lanes);
  endfunction

endpackage

// File: rtl/kws_simd_dot_stage.sv
// Registered offset-adjust and multiply across LANES int8 lanes; the registered
// products are reduced combinationally into a signed lane sum.
module kws_simd_dot_stage
  import kws_simd_mac_pkg::*;
#(
  parameter int LANES = 4,
  localparam int SUM_W = lane_sum_w(LANES)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    lane0_only_i,
  input  logic [31:0]             in0_i,
  input  logic [31:0]             in1_i,
  input  logic [OFF_W-1:0]        offset_i,
  output logic signed [SUM_W-1:0] sum_o
);

  logic signed [OFF_W-1:0]  adj_s  [LANES];
  logic signed [ELEM_W-1:0] wt_s   [LANES];
  logic signed [PROD_W-1:0] prod_d [LANES];
  logic signed [PROD_W-1:0] prod_q [LANES];
  logic signed [SUM_W-1:0]  sum_s;
  logic                     unused_s;

  assign unused_s = ^{in0_i, in1_i};

  // The offset-adjusted activation deliberately wraps to 9 bits.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      adj_s[i]  = {in0_i[ELEM_W*i + ELEM_W - 1], in0_i[ELEM_W*i +: ELEM_W]} + offset_i;
      wt_s[i]   = in1_i[ELEM_W*i +: ELEM_W];
      prod_d[i] = (lane0_only_i && (i != 0)) ? '0
                : PROD_W'(adj_s[i]) * PROD_W'(wt_s[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (en_i) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
    end
  end

  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) sum_s = sum_s + SUM_W'(prod_q[i]);
  end

  assign sum_o = sum_s;

endmodule

// File: rtl/kws_simd_mac_pipe.sv
// Pipelined KWS SIMD MAC CFU: FSM, input-offset register and accumulator bank.
// Define KWS_SIMD_MAC_SATURATE_EN for saturating accumulation with sticky overflow flags.
module kws_simd_mac_pipe
  import kws_simd_mac_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int NUM_ACC    = 4,
  parameter int ACC_W      = 32,
  parameter int OFFSET_RST = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_payload_response_ok,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int SEL_W  = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int SUM_W  = lane_sum_w(LANES);
  localparam int WIDE_W = 34;
  localparam logic signed [WIDE_W-1:0] ACC_MAX_W = (WIDE_W'(1) << (ACC_W - 1)) - WIDE_W'(1);
  localparam logic signed [WIDE_W-1:0] ACC_MIN_W = ~ACC_MAX_W;

  state_e               state_q;
  op_e                  op_q;
  logic [SEL_W-1:0]     sel_q;
  logic [OFF_W-1:0]     off_in_q;
  logic [OFF_W-1:0]     offset_q;
  logic [ACC_W-1:0]     acc_q [NUM_ACC];
  logic                 cmd_ready_q;
  logic                 rsp_valid_q;
  logic [31:0]          rsp_data_q;
`ifdef KWS_SIMD_MAC_SATURATE_EN
  logic [NUM_ACC-1:0]   flag_q;
`endif

  logic [SEL_W-1:0]         sel_s;
  logic                     issue_s;
  logic signed [SUM_W-1:0]  sum_s;
  logic [ACC_W-1:0]         acc_cur_s;
  logic signed [WIDE_W-1:0] acc_wide_s;
  logic signed [WIDE_W-1:0] sum_wide_s;
  logic signed [WIDE_W-1:0] acc_sum_s;
  logic [ACC_W-1:0]         acc_mac_d;
  logic                     sat_s;
  logic [31:0]              mac_rsp_s;
  logic [31:0]              rd_rsp_s;
  logic                     unused_s;

  assign unused_s = ^cmd_payload_function_id[9:3];
  assign sel_s    = (NUM_ACC > 1) ? cmd_payload_function_id[3 +: SEL_W] : '0;
  assign issue_s  = (state_q == IDLE) && cmd_valid;

  kws_simd_dot_stage #(.LANES(LANES)) u_dot (
    .clk          (clk),
    .reset        (reset),
    .en_i         (issue_s),
    .lane0_only_i (cmd_payload_function_id[2:0] == OP_MAC1),
    .in0_i        (cmd_payload_inputs_0),
    .in1_i        (cmd_payload_inputs_1),
    .offset_i     (offset_q),
    .sum_o        (sum_s)
  );

  // Accumulate in a wide domain so both wrap and saturation fall out of one adder.
  always_comb begin
    acc_cur_s                = acc_q[sel_q];
    acc_wide_s               = {WIDE_W{acc_cur_s[ACC_W-1]}};
    acc_wide_s[ACC_W-1:0]    = acc_cur_s;
    sum_wide_s               = {WIDE_W{sum_s[SUM_W-1]}};
    sum_wide_s[SUM_W-1:0]    = sum_s;
    acc_sum_s                = acc_wide_s + sum_wide_s;
    acc_mac_d                = acc_sum_s[ACC_W-1:0];
    sat_s                    = 1'b0;
`ifdef KWS_SIMD_MAC_SATURATE_EN
    if (acc_sum_s > ACC_MAX_W) begin
      acc_mac_d = ACC_MAX_W[ACC_W-1:0];
      sat_s     = 1'b1;
    end else if (acc_sum_s < ACC_MIN_W) begin
      acc_mac_d = ACC_MIN_W[ACC_W-1:0];
      sat_s     = 1'b1;
    end else begin
      acc_mac_d = acc_sum_s[ACC_W-1:0];
    end
`endif
    mac_rsp_s                = {32{acc_mac_d[ACC_W-1]}};
    mac_rsp_s[ACC_W-1:0]     = acc_mac_d;
    rd_rsp_s                 = {32{acc_cur_s[ACC_W-1]}};
    rd_rsp_s[ACC_W-1:0]      = acc_cur_s;
`ifdef KWS_SIMD_MAC_SATURATE_EN
    rd_rsp_s[31]             = (ACC_W < 32) ? flag_q[sel_q] : acc_cur_s[ACC_W-1];
`endif
  end

  // Command FSM; the accumulator bank and offset register only change in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP6;
      sel_q       <= '0;
      off_in_q    <= '0;
      offset_q    <= OFF_W'(OFFSET_RST);
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
`ifdef KWS_SIMD_MAC_SATURATE_EN
      flag_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q        <= op_e'(cmd_payload_function_id[2:0]);
            sel_q       <= sel_s;
            off_in_q    <= cmd_payload_inputs_0[OFF_W-1:0];
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
          case (op_q)
            OP_MAC, OP_MAC1: begin
              acc_q[sel_q] <= acc_mac_d;
              rsp_data_q   <= mac_rsp_s;
`ifdef KWS_SIMD_MAC_SATURATE_EN
              flag_q[sel_q] <= flag_q[sel_q] | sat_s;
`endif
            end
            OP_SETOFF: begin
              offset_q   <= off_in_q;
              rsp_data_q <= {{23{offset_q[OFF_W-1]}}, offset_q};
            end
            OP_READ: rsp_data_q <= rd_rsp_s;
            OP_CLEAR, OP_READCLR: begin
              acc_q[sel_q] <= '0;
              rsp_data_q   <= (op_q == OP_READCLR) ? rd_rsp_s : 32'd0;
`ifdef KWS_SIMD_MAC_SATURATE_EN
              flag_q[sel_q] <= 1'b0;
`endif
            end
            default: rsp_data_q <= 32'd0;
          endcase
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready               = cmd_ready_q;
  assign rsp_valid               = rsp_valid_q;
  assign rsp_payload_outputs_0   = rsp_data_q;
  assign rsp_payload_response_ok = 1'b1;

endmodule

// File: tb/tb_kws_simd_mac_pipe.sv
// Scoreboard bench for kws_simd_mac_pipe (ACC_W=16); expectations follow KWS_SIMD_MAC_SATURATE_EN.
module tb_kws_simd_mac_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  fid;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic [31:0] rsp_out;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] mon_exp;
  string       mon_nm;

  always #5 clk = ~clk;

  kws_simd_mac_pipe #(.LANES(4), .NUM_ACC(4), .ACC_W(16), .OFFSET_RST(128)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_response_ok (rsp_ok),
    .rsp_payload_outputs_0   (rsp_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", rsp_out, 32'hDEADBEEF ^ rsp_out);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        chk(mon_nm, rsp_out, mon_exp);
        chk({mon_nm, "_ok"}, {31'd0, rsp_ok}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    fid = f; in0 = a; in1 = b; cmd_valid = 1'b1;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (cmd_ready !== 1'b1) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      nm_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    issue(f, a, b);
    drain();
  endtask

  initial begin
    int g;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    fid = 10'd0; in0 = 32'd0; in1 = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data",  rsp_out, 32'd0);
    @(posedge clk); #1;

    op(10'h003, 32'd0, 32'd0, 32'd0, "read_acc0_rst");
    op(10'h002, 32'd0, 32'd0, 32'd128, "setoff_prev_rst");
    op(10'h002, 32'd128, 32'd0, 32'd0, "setoff_prev_zero");
    op(10'h008, 32'h01020304, 32'h01010101, 32'd522, "mac_acc1_first");
    op(10'h008, 32'h01020304, 32'h01010101, 32'd1044, "mac_acc1_second");
    op(10'h003, 32'd0, 32'd0, 32'd0, "read_acc0_indep");
    op(10'h002, 32'd0, 32'd0, 32'd128, "setoff_prev_128");
    op(10'h011, 32'hFFFFFF80, 32'h0000007F, 32'hFFFFC080, "mac1_acc2_neg");
    op(10'h015, 32'd0, 32'd0, 32'hFFFFC080, "readclr_acc2");
    op(10'h013, 32'd0, 32'd0, 32'd0, "read_acc2_cleared");
    op(10'h006, 32'h12345678, 32'h12345678, 32'd0, "nop6");

    // Back-pressure: response must hold and a queued command must wait.
    rsp_ready = 1'b0;
    exp_q.push_back(32'd1044); nm_q.push_back("stall_read_acc1");
    issue(10'h00B, 32'd0, 32'd0);
    g = 0;
    while (rsp_valid !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("stall_rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    exp_q.push_back(32'd0); nm_q.push_back("held_read_acc0");
    fid = 10'h003; cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", rsp_out, 32'd1044);
      chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(10'h003, 32'd0, 32'd0);
    drain();

    op(10'h00C, 32'd0, 32'd0, 32'd0, "clear_acc1");
    op(10'h00B, 32'd0, 32'd0, 32'd0, "read_acc1_cleared");
    op(10'h008, 32'h01020304, 32'h01010101, 32'd10, "mac_acc1_off0");

    // Reset while the MAC to acc3 sits in EXEC: no response, no update.
    issue(10'h018, 32'h01020304, 32'h01010101);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_data",  rsp_out, 32'd0);
    @(posedge clk); #1;
    op(10'h01B, 32'd0, 32'd0, 32'd0, "read_acc3_after_rst");
    op(10'h00B, 32'd0, 32'd0, 32'd0, "read_acc1_after_rst");
    op(10'h002, 32'd128, 32'd0, 32'd128, "offset_after_rst");

`ifdef KWS_SIMD_MAC_SATURATE_EN
    op(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00007FFF, "sat_mac_first");
    op(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00007FFF, "sat_mac_second");
    op(10'h003, 32'd0, 32'd0, 32'h80007FFF, "sat_read_flag");
    op(10'h005, 32'd0, 32'd0, 32'h80007FFF, "sat_readclr_flag");
`else
    op(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFFA04, "wrap_mac_first");
    op(10'h000, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'hFFFFF408, "wrap_mac_second");
    op(10'h003, 32'd0, 32'd0, 32'hFFFFF408, "wrap_read");
    op(10'h005, 32'd0, 32'd0, 32'hFFFFF408, "wrap_readclr");
`endif
    op(10'h003, 32'd0, 32'd0, 32'd0, "read_acc0_final");

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
